// File: rtl/uart_rx_if.sv
// Byte-side handshake of the serial receiver: one-entry valid/ready buffer plus error pulses.
interface uart_rx_if;
  logic [7:0] rx_data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;

  modport master (output rx_data_o, valid_o, frame_err_o, overrun_o, input ready_i);
  modport slave  (input rx_data_o, valid_o, frame_err_o, overrun_o, output ready_i);
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF synchronizer, mid-bit sampling FSM, one-entry output buffer
// with single-cycle framing-error and overrun pulses.
module uart_rx #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BIT_RATE = 9600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  uart_rx_if.master  rx_if
);
  localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic          rx_meta, rxs;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          good_stop, bad_stop;
  logic          dlv_q;
  logic [7:0]    data_q;
  logic          valid_q, ferr_q, ovr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        // A start bit that is high again at its midpoint is treated as line noise.
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            good_stop = 1'b1;
            state_d   = IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // shift_q is frozen outside DATA, so it is still the finished byte when dlv_q fires.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dlv_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      dlv_q  <= good_stop;
      ferr_q <= bad_stop;
      ovr_q  <= 1'b0;
      if (dlv_q) begin
        if (valid_q && !rx_if.ready_i) begin
          ovr_q <= 1'b1;
        end else begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end
      end else if (valid_q && rx_if.ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data_o   = data_q;
  assign rx_if.valid_o     = valid_q;
  assign rx_if.frame_err_o = ferr_q;
  assign rx_if.overrun_o   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit; each scenario checks its own results.
module tb_uart_rx;
  localparam int CLK_HZ   = 1_000_000;
  localparam int BIT_RATE = 100_000;
  localparam int CPB      = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_if bus();

  uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rx_i  (rx),
    .rx_if (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (bus.valid_o && bus.ready_i) got_q.push_back(bus.rx_data_o);
    if (bus.frame_err_o) ferr_cnt++;
    if (bus.overrun_o) ovr_cnt++;
  end

  // Callers stay aligned at 1 time unit after a rising edge.
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic wait_got(input int n, output bit ok);
    int t = 0;
    while (got_q.size() < n && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
    n_vec++; if (bus.rx_data_o !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.rx_data_o); end
    n_vec++; if (bus.frame_err_o !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err_o); end
    n_vec++; if (bus.overrun_o !== 1'b0) begin n_err++; $display("FAIL reset_ovr: got %b want 0", bus.overrun_o); end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_single;
    int lat = 0;
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    bit ok;
    logic [7:0] e, g;
    bus.ready_i = 1'b1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (bus.valid_o !== 1'b1 && lat < 200) begin
          @(posedge clk); #1;
          lat++;
        end
        // expected ~2 sync + 5 half + 80 data + 10 stop + 1 deliver clocks
        n_vec++; if (lat < 96 || lat > 100) begin n_err++; $display("FAIL single_latency: got %0d clks want 96..100", lat); end
        n_vec++; if (bus.rx_data_o !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", bus.rx_data_o); end
        @(posedge clk); #1;
        n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL single_pulse: valid got %b want 0", bus.valid_o); end
      end
    join
    wait_got(1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL single_timeout: got %0d bytes want 1", got_q.size()); end
    else begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      if (g !== e) begin n_err++; $display("FAIL single_sb: got %h want %h", g, e); end
    end
    n_vec++; if (ferr_cnt != f0 || ovr_cnt != o0) begin n_err++; $display("FAIL single_flags: ferr %0d ovr %0d want 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat [4];
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    bit ok;
    logic [7:0] e, g;
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55; pat[3] = 8'h3C;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pat[i]);
      send_frame(pat[i], 1'b1);
    end
    wait_got(4, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_count: got %0d bytes want 4", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL b2b_data: got %h want %h", g, e); end
    end
    exp_q.delete();
    n_vec++; if (ferr_cnt != f0 || ovr_cnt != o0) begin n_err++; $display("FAIL b2b_flags: ferr %0d ovr %0d want 0 0", ferr_cnt - f0, ovr_cnt - o0); end
  endtask

  task automatic test_glitch;
    int f0 = ferr_cnt;
    int o0 = ovr_cnt;
    bit ok;
    logic [7:0] g;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL glitch_bytes: got %0d bytes want 0", got_q.size()); end
    n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b want 0", bus.valid_o); end
    n_vec++; if (ferr_cnt != f0 || ovr_cnt != o0) begin n_err++; $display("FAIL glitch_flags: ferr %0d ovr %0d want 0 0", ferr_cnt - f0, ovr_cnt - o0); end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    wait_got(1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL glitch_recover: got %0d bytes want 1", got_q.size()); end
    else begin
      g = got_q.pop_front();
      if (g !== exp_q.pop_front()) begin n_err++; $display("FAIL glitch_recover: got %h want 5a", g); end
    end
    exp_q.delete();
  endtask

  task automatic test_break;
    int f0 = ferr_cnt;
    bit ok;
    logic [7:0] g;
    send_frame(8'h12, 1'b0);
    for (int i = 0; i < 30; i++) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL break_nodata: got %0d bytes want 0", got_q.size()); end
    n_vec++; if (ferr_cnt - f0 != 1) begin n_err++; $display("FAIL break_ferr: got %0d pulses want 1", ferr_cnt - f0); end
    exp_q.push_back(8'h34);
    send_frame(8'h34, 1'b1);
    wait_got(1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL break_next: got %0d bytes want 1", got_q.size()); end
    else begin
      g = got_q.pop_front();
      if (g !== exp_q.pop_front()) begin n_err++; $display("FAIL break_next: got %h want 34", g); end
    end
    exp_q.delete();
    n_vec++; if (ferr_cnt - f0 != 1) begin n_err++; $display("FAIL break_ferr_total: got %0d pulses want 1", ferr_cnt - f0); end
  endtask

  task automatic test_overrun;
    int o0 = ovr_cnt;
    logic [7:0] g;
    bus.ready_i = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    n_vec++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", bus.valid_o); end
    n_vec++; if (bus.rx_data_o !== 8'h11) begin n_err++; $display("FAIL ovr_hold: got %h want 11", bus.rx_data_o); end
    n_vec++; if (ovr_cnt - o0 != 1) begin n_err++; $display("FAIL ovr_pulse: got %0d pulses want 1", ovr_cnt - o0); end
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL ovr_consume: valid got %b want 0", bus.valid_o); end
    n_vec++;
    if (got_q.size() != 1) begin n_err++; $display("FAIL ovr_sb_count: got %0d bytes want 1", got_q.size()); end
    else begin
      g = got_q.pop_front();
      if (g !== exp_q.pop_front()) begin n_err++; $display("FAIL ovr_sb: got %h want 11", g); end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset_midframe;
    bit ok;
    logic [7:0] g;
    bus.ready_i = 1'b1;
    // 0x77 is abandoned while its line level is high, so nothing stray follows the reset.
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (bus.valid_o !== 1'b0 || bus.rx_data_o !== 8'h00 || bus.frame_err_o !== 1'b0 || bus.overrun_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_during: v=%b d=%h fe=%b ov=%b want 0 00 0 0", bus.valid_o, bus.rx_data_o, bus.frame_err_o, bus.overrun_o);
    end
    rst = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    n_vec++; if (got_q.size() != 0 || bus.valid_o !== 1'b0 || bus.rx_data_o !== 8'h00 || bus.frame_err_o !== 1'b0) begin
      n_err++; $display("FAIL rstmid_after: bytes=%0d v=%b d=%h fe=%b want 0 0 00 0", got_q.size(), bus.valid_o, bus.rx_data_o, bus.frame_err_o);
    end
    exp_q.push_back(8'h88);
    send_frame(8'h88, 1'b1);
    wait_got(1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rstmid_next: got %0d bytes want 1", got_q.size()); end
    else begin
      g = got_q.pop_front();
      if (g !== exp_q.pop_front()) begin n_err++; $display("FAIL rstmid_next: got %h want 88", g); end
    end
    exp_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_break;
    test_overrun;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
